// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller:
// forwarding select encodings, the $zero specifier and the shadow stage tag.
package forwarding_hazard_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Priority comparator choosing the ALU operand source for one EX operand.
// Purely combinational; the MEM stage beats WB so the newest producer wins.
module fwd_select
  import forwarding_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             mem_regwrite_i,
  input  logic [REG_W-1:0] mem_dst_i,
  input  logic             wb_regwrite_i,
  input  logic [REG_W-1:0] wb_dst_i,
  output logic [1:0]       sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (mem_regwrite_i && (mem_dst_i != REG_ZERO) && (mem_dst_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_regwrite_i && (wb_dst_i != REG_ZERO) && (wb_dst_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline: shadow EX/MEM/WB tags,
// registered-only forwarding selects, load-use stall with ID/EX bubble, flush squash.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_count
);

  stage_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  stage_tag_t id_tag;
  logic       load_use;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    id_tag          = TAG_BUBBLE;
    id_tag.valid    = 1'b1;
    id_tag.regwrite = id_regwrite;
    id_tag.memread  = id_memread;
    id_tag.dst      = REG_W'(id_dst);
    id_tag.rs       = REG_W'(id_rs);
    id_tag.rt       = REG_W'(id_rt);
  end

  assign load_use = id_valid && ex_q.memread && (ex_q.dst != REG_ZERO) &&
                    ((id_uses_rs && (id_tag.rs == ex_q.dst)) ||
                     (id_uses_rt && (id_tag.rt == ex_q.dst)));

  // Inputs are ignored while reset is held, so the hazard outputs are masked too.
  assign stall       = load_use && !flush && !reset;
  assign idex_bubble = (load_use || flush) && !reset;

  always_comb begin
    ex_d  = (id_valid && !stall && !flush) ? id_tag : TAG_BUBBLE;
    mem_d = flush ? TAG_BUBBLE : ex_q;
    wb_d  = mem_q;
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q  <= TAG_BUBBLE;
      mem_q <= TAG_BUBBLE;
      wb_q  <= TAG_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

  // Selects depend only on registered tags, keeping them off any input-to-output path.
  fwd_select u_fwd_a (
    .src_i          (ex_q.rs),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_dst_i      (mem_q.dst),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_dst_i       (wb_q.dst),
    .sel_o          (forward_a)
  );

  fwd_select u_fwd_b (
    .src_i          (ex_q.rt),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_dst_i      (mem_q.dst),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_dst_i       (wb_q.dst),
    .sel_o          (forward_b)
  );

  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.valid, wb_q.memread, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_forwarding_hazard_unit;

  logic       clock;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic       flush;

  logic [1:0]  forward_a, forward_b;
  logic        stall, idex_bubble;
  logic [15:0] stall_count;

  logic [1:0]  s_forward_a, s_forward_b;
  logic        s_stall, s_idex_bubble;
  logic [1:0]  s_stall_count;

  int checks;
  int fails;

  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .idex_bubble(idex_bubble), .stall_count(stall_count)
  );

  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .forward_a(s_forward_a), .forward_b(s_forward_b), .stall(s_stall),
    .idex_bubble(s_idex_bubble), .stall_count(s_stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    nop();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd0) begin
      $display("FAIL reset_fwd: a=%0d b=%0d expected 0 0", forward_a, forward_b); fails++;
    end
    checks++;
    if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
      $display("FAIL reset_stall: stall=%0b bubble=%0b expected 0 0", stall, idex_bubble); fails++;
    end
    checks++;
    if (stall_count !== 16'd0) begin
      $display("FAIL reset_count: got %0d expected 0", stall_count); fails++;
    end
  endtask

  task automatic test_raw_back_to_back();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
    step();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // sub $4,$3,$5
    #1;
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL raw_no_stall: stall=%0b expected 0", stall); fails++;
    end
    step();
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd2 || forward_b !== 2'd0) begin
      $display("FAIL raw_fwd: a=%0d b=%0d expected 2 0", forward_a, forward_b); fails++;
    end
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL raw_no_stall2: stall=%0b expected 0", stall); fails++;
    end
  endtask

  task automatic test_distance2();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3
    step();
    nop();
    step();
    drive(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // or $6,$7,$3
    step();
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd1) begin
      $display("FAIL dist2_fwd: a=%0d b=%0d expected 0 1", forward_a, forward_b); fails++;
    end
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd2) begin
      $display("FAIL mem_beats_wb: a=%0d b=%0d expected 0 2", forward_a, forward_b); fails++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw $8,0($9)
    step();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // add $10,$8,$8
    #1;
    checks++;
    if (stall !== 1'b1 || idex_bubble !== 1'b1) begin
      $display("FAIL lu_stall: stall=%0b bubble=%0b expected 1 1", stall, idex_bubble); fails++;
    end
    checks++;
    if (stall_count !== 16'd0) begin
      $display("FAIL lu_count0: got %0d expected 0", stall_count); fails++;
    end
    step();
    #1;
    checks++;
    if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
      $display("FAIL lu_one_cycle: stall=%0b bubble=%0b expected 0 0", stall, idex_bubble); fails++;
    end
    checks++;
    if (stall_count !== 16'd1) begin
      $display("FAIL lu_count1: got %0d expected 1", stall_count); fails++;
    end
    step();
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd1 || forward_b !== 2'd1) begin
      $display("FAIL lu_fwd: a=%0d b=%0d expected 1 1", forward_a, forward_b); fails++;
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw $0
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add $0,$0,$0
    #1;
    checks++;
    if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
      $display("FAIL zero_no_stall: stall=%0b bubble=%0b expected 0 0", stall, idex_bubble); fails++;
    end
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // or $5,$0,$0
    step();
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd0) begin
      $display("FAIL zero_no_fwd: a=%0d b=%0d expected 0 0", forward_a, forward_b); fails++;
    end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
    step();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw $8
    step();
    drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // add $10,$8,$3
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || idex_bubble !== 1'b1) begin
      $display("FAIL flush_prio: stall=%0b bubble=%0b expected 0 1", stall, idex_bubble); fails++;
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd0) begin
      $display("FAIL flush_fwd: a=%0d b=%0d expected 0 0", forward_a, forward_b); fails++;
    end
    checks++;
    if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
      $display("FAIL flush_ex_squash: stall=%0b bubble=%0b expected 0 0", stall, idex_bubble); fails++;
    end
    step();
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd0) begin
      $display("FAIL flush_mem_squash: a=%0d b=%0d expected 0 0", forward_a, forward_b); fails++;
    end
    checks++;
    if (stall_count !== 16'd0) begin
      $display("FAIL flush_count: got %0d expected 0", stall_count); fails++;
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    step();
    step();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1 || stall_count !== 16'd1) begin
      $display("FAIL mid_pre: stall=%0b count=%0d expected 1 1", stall, stall_count); fails++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
      $display("FAIL mid_reset_cycle: stall=%0b bubble=%0b expected 0 0", stall, idex_bubble); fails++;
    end
    step();
    reset = 1'b0;
    nop();
    #1;
    checks++;
    if (forward_a !== 2'd0 || forward_b !== 2'd0 || stall !== 1'b0 ||
        idex_bubble !== 1'b0 || stall_count !== 16'd0) begin
      $display("FAIL mid_after: a=%0d b=%0d stall=%0b bubble=%0b count=%0d expected all 0",
               forward_a, forward_b, stall, idex_bubble, stall_count); fails++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
      step();
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
      step();
      step();
      nop();
      if (i == 2) begin
        checks++;
        if (s_stall_count !== 2'd3) begin
          $display("FAIL sat_reach: got %0d expected 3", s_stall_count); fails++;
        end
      end
    end
    step();
    checks++;
    if (s_stall_count !== 2'd3) begin
      $display("FAIL sat_hold: got %0d expected 3", s_stall_count); fails++;
    end
    checks++;
    if (stall_count !== 16'd5) begin
      $display("FAIL wide_count: got %0d expected 5", stall_count); fails++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    flush  = 1'b0;
    nop();
    test_reset();
    test_raw_back_to_back();
    test_distance2();
    test_load_use();
    test_zero_reg();
    test_flush_vs_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
